// File: rtl/anabellek_obek_okuyucu_if.sv
// Request, block result and memory word-bus signals of the block reader.
// The slave modport is the reader's view; the master modport is the cache and memory side.
interface anabellek_obek_okuyucu_if;
    logic         istek_i;
    logic         oku_i;
    logic [31:0]  adres_i;
    logic         musait_o;
    logic         hazir_o;
    logic [127:0] obek_o;
    logic         hata_o;
    logic         bellek_gecerli_o;
    logic [31:0]  bellek_adres_o;
    logic         bellek_hazir_i;
    logic         bellek_veri_gecerli_i;
    logic [31:0]  bellek_veri_i;

    modport slave (
        input  istek_i, oku_i, adres_i,
        input  bellek_hazir_i, bellek_veri_gecerli_i, bellek_veri_i,
        output musait_o, hazir_o, obek_o, hata_o,
        output bellek_gecerli_o, bellek_adres_o
    );

    modport master (
        output istek_i, oku_i, adres_i,
        output bellek_hazir_i, bellek_veri_gecerli_i, bellek_veri_i,
        input  musait_o, hazir_o, obek_o, hata_o,
        input  bellek_gecerli_o, bellek_adres_o
    );
endinterface

// File: rtl/anabellek_obek_okuyucu.sv
// Reads one 16-byte block as four sequential 32-bit words, one read outstanding at a time,
// with a per-word response timeout that ends the block early and flags it as failed.
module anabellek_obek_okuyucu #(
    parameter int unsigned BEKLEME_SINIRI = 1023
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    anabellek_obek_okuyucu_if.slave        bus
);
    // The counter only has to reach BEKLEME_SINIRI-1: the final no-data cycle ends the wait.
    localparam int unsigned SAYAC_W = (BEKLEME_SINIRI < 2) ? 1 : $clog2(BEKLEME_SINIRI);
    localparam logic [SAYAC_W-1:0] SAYAC_SON = SAYAC_W'(BEKLEME_SINIRI - 1);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        BEKLE = 2'd2,
        TAMAM = 2'd3
    } durum_t;

    durum_t               durum_q, durum_d;
    logic [27:0]          taban_q, taban_d;
    logic [1:0]           k_q, k_d;
    logic [SAYAC_W-1:0]   sayac_q, sayac_d;
    logic                 hata_bayrak_q, hata_bayrak_d;
    logic [127:0]         obek_q, obek_d;
    logic                 musait_q, musait_d;
    logic                 hazir_q, hazir_d;
    logic                 hata_q, hata_d;
    logic                 gecerli_q, gecerli_d;
    logic [31:0]          badres_q, badres_d;

    logic                 unused_adres_alt;
    assign unused_adres_alt = ^bus.adres_i[3:0];

    always_comb begin
        durum_d       = durum_q;
        taban_d       = taban_q;
        k_d           = k_q;
        sayac_d       = sayac_q;
        hata_bayrak_d = hata_bayrak_q;
        obek_d        = obek_q;

        case (durum_q)
            BOSTA: begin
                if (bus.istek_i && bus.oku_i) begin
                    taban_d       = bus.adres_i[31:4];
                    k_d           = 2'd0;
                    sayac_d       = '0;
                    hata_bayrak_d = 1'b0;
                    obek_d        = '0;
                    durum_d       = ISTEK;
                end
            end
            ISTEK: begin
                if (bus.bellek_hazir_i) begin
                    sayac_d = '0;
                    durum_d = BEKLE;
                end
            end
            BEKLE: begin
                if (bus.bellek_veri_gecerli_i) begin
                    obek_d[{k_q, 5'd0} +: 32] = bus.bellek_veri_i;
                    k_d     = k_q + 2'd1;
                    durum_d = (k_q == 2'd3) ? TAMAM : ISTEK;
                end else if (sayac_q == SAYAC_SON) begin
                    hata_bayrak_d = 1'b1;
                    durum_d       = TAMAM;
                end else begin
                    sayac_d = sayac_q + 1'b1;
                end
            end
            TAMAM: begin
                hata_bayrak_d = 1'b0;
                durum_d       = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase

        // Outputs are decoded from the next state so they are registered yet align with the state.
        musait_d  = (durum_d == BOSTA);
        hazir_d   = (durum_d == TAMAM);
        hata_d    = (durum_d == TAMAM) && hata_bayrak_d;
        gecerli_d = (durum_d == ISTEK);
        // Word offset is spliced below the base, so it can never carry into base[31:4].
        badres_d  = gecerli_d ? {taban_d, k_d, 2'b00} : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q       <= BOSTA;
            taban_q       <= '0;
            k_q           <= 2'd0;
            sayac_q       <= '0;
            hata_bayrak_q <= 1'b0;
            obek_q        <= '0;
            musait_q      <= 1'b1;
            hazir_q       <= 1'b0;
            hata_q        <= 1'b0;
            gecerli_q     <= 1'b0;
            badres_q      <= 32'd0;
        end else begin
            durum_q       <= durum_d;
            taban_q       <= taban_d;
            k_q           <= k_d;
            sayac_q       <= sayac_d;
            hata_bayrak_q <= hata_bayrak_d;
            obek_q        <= obek_d;
            musait_q      <= musait_d;
            hazir_q       <= hazir_d;
            hata_q        <= hata_d;
            gecerli_q     <= gecerli_d;
            badres_q      <= badres_d;
        end
    end

    assign bus.musait_o         = musait_q;
    assign bus.hazir_o          = hazir_q;
    assign bus.hata_o           = hata_q;
    assign bus.obek_o           = obek_q;
    assign bus.bellek_gecerli_o = gecerli_q;
    assign bus.bellek_adres_o   = badres_q;
endmodule

// File: tb/tb_anabellek_obek_okuyucu.sv
// Directed and randomized block reads against a transaction-level model of the block reader:
// expected block, bus addresses and completion latency derive from the stimulus alone.
module tb_anabellek_obek_okuyucu;
    localparam int L = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    anabellek_obek_okuyucu_if bus();

    anabellek_obek_okuyucu #(.BEKLEME_SINIRI(L)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int ne = 0;

    logic [31:0] words [4];
    int          hs [4];
    int          dl [4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        ne++;
    endtask

    task automatic clear_inputs();
        bus.istek_i               = 1'b0;
        bus.oku_i                 = 1'b0;
        bus.adres_i               = 32'd0;
        bus.bellek_hazir_i        = 1'b0;
        bus.bellek_veri_gecerli_i = 1'b0;
        bus.bellek_veri_i         = 32'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_musait"},  bus.musait_o, 1);
        chk({tag, "_hazir"},   bus.hazir_o, 0);
        chk({tag, "_hata"},    bus.hata_o, 0);
        chk({tag, "_gecerli"}, bus.bellek_gecerli_o, 0);
        chk({tag, "_badres"},  bus.bellek_adres_o, 0);
        chk({tag, "_obek"},    bus.obek_o, 0);
    endtask

    // Random request and ignored-data traffic while the reader is busy.
    task automatic noise(input bit noisy);
        if (noisy) begin
            bus.istek_i               = 1'($urandom);
            bus.oku_i                 = 1'($urandom);
            bus.adres_i               = $urandom;
            bus.bellek_veri_gecerli_i = 1'($urandom);
            bus.bellek_veri_i         = $urandom;
        end else begin
            bus.istek_i               = 1'b0;
            bus.bellek_veri_gecerli_i = 1'b0;
        end
    endtask

    task automatic accept(input logic [31:0] addr, output int t0);
        tick();
        chk("kabul_musait", bus.musait_o, 1);
        bus.istek_i = 1'b1;
        bus.oku_i   = 1'b1;
        bus.adres_i = addr;
        t0 = ne;
        tick();
        bus.istek_i = 1'b0;
        bus.oku_i   = 1'b0;
        bus.adres_i = $urandom;
    endtask

    // Request phase of word w: hs[w] stall cycles, then the handshake; ends in the wait state.
    task automatic request_word(input logic [31:0] base, input int w, input bit noisy);
        logic [31:0] a;
        a = base + 32'(4 * w);
        for (int s = 0; s < hs[w]; s++) begin
            chk("istek_gecerli_bekletme", bus.bellek_gecerli_o, 1);
            chk("istek_adres_bekletme", bus.bellek_adres_o, a);
            chk("istek_musait", bus.musait_o, 0);
            bus.bellek_hazir_i = 1'b0;
            noise(noisy);
            tick();
        end
        chk("istek_gecerli", bus.bellek_gecerli_o, 1);
        chk("istek_adres", bus.bellek_adres_o, a);
        bus.bellek_hazir_i = 1'b1;
        noise(noisy);
        tick();
        bus.bellek_hazir_i = noisy ? 1'($urandom) : 1'b0;
        chk("bekle_gecerli", bus.bellek_gecerli_o, 0);
        chk("bekle_badres", bus.bellek_adres_o, 0);
        chk("bekle_musait", bus.musait_o, 0);
    endtask

    task automatic run_block(input logic [31:0] addr, input bit noisy);
        logic [31:0]  base;
        logic [127:0] exp_blk;
        int           t0;
        int           extra;
        base    = addr & 32'hFFFF_FFF0;
        exp_blk = {words[3], words[2], words[1], words[0]};
        extra   = 0;
        for (int i = 0; i < 4; i++) extra += hs[i] + dl[i];
        accept(addr, t0);
        for (int w = 0; w < 4; w++) begin
            request_word(base, w, noisy);
            for (int d = 0; d < dl[w]; d++) begin
                bus.bellek_veri_gecerli_i = 1'b0;
                bus.bellek_veri_i         = $urandom;
                if (noisy) bus.istek_i = 1'($urandom);
                tick();
                chk("gecikme_gecerli", bus.bellek_gecerli_o, 0);
                chk("gecikme_hazir", bus.hazir_o, 0);
            end
            bus.bellek_veri_gecerli_i = 1'b1;
            bus.bellek_veri_i         = words[w];
            tick();
            bus.bellek_veri_gecerli_i = 1'b0;
            bus.bellek_veri_i         = $urandom;
        end
        chk("tamam_hazir", bus.hazir_o, 1);
        chk("tamam_hata", bus.hata_o, 0);
        chk("tamam_gecikme", 128'(ne - t0), 128'(9 + extra));
        chk("tamam_obek", bus.obek_o, exp_blk);
        chk("tamam_musait", bus.musait_o, 0);
        chk("tamam_gecerli", bus.bellek_gecerli_o, 0);
        bus.istek_i = 1'b1;
        bus.oku_i   = 1'b1;
        bus.adres_i = $urandom;
        tick();
        chk("tamam_sonrasi_musait", bus.musait_o, 1);
        chk("tamam_sonrasi_hazir", bus.hazir_o, 0);
        chk("obek_tutuldu", bus.obek_o, exp_blk);
        clear_inputs();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int t0;
        int n;
        logic [127:0] exp_blk;

        clear_inputs();
        tick();
        tick();
        check_reset_outputs("reset");
        rst_i = 1'b1;
        tick();
        check_reset_outputs("reset_sonrasi");

        // Request without the read qualifier must be ignored.
        bus.istek_i = 1'b1;
        bus.oku_i   = 1'b0;
        bus.adres_i = 32'h0000_4440;
        tick();
        chk("oku0_musait", bus.musait_o, 1);
        chk("oku0_gecerli", bus.bellek_gecerli_o, 0);
        tick();
        chk("oku0_musait2", bus.musait_o, 1);
        clear_inputs();

        // Zero-wait read of 0x1238.
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        hs = '{0, 0, 0, 0};
        dl = '{0, 0, 0, 0};
        run_block(32'h0000_1238, 1'b0);
        chk("sifir_bekleme_obek_sabit", bus.obek_o,
            128'h00000044_00000033_00000022_00000011);

        // Five backpressure cycles on word 2.
        words = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'hD4D4_0004};
        hs = '{0, 0, 5, 0};
        run_block(32'h8000_0FF4, 1'b0);

        // Requests and stray data while busy.
        words = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0};
        hs = '{0, 0, 0, 0};
        run_block(32'hFFFF_FFFC, 1'b1);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) begin
                words[i] = $urandom;
                hs[i]    = int'($urandom_range(3, 0));
                dl[i]    = int'($urandom_range(L - 2, 0));
            end
            run_block($urandom, 1'($urandom));
        end

        // Timeout on word 1.
        words = '{32'h5555_AAAA, 32'h0, 32'h0, 32'h0};
        hs = '{0, 0, 0, 0};
        dl = '{0, 0, 0, 0};
        accept(32'h0000_2000, t0);
        request_word(32'h0000_2000, 0, 1'b0);
        bus.bellek_veri_gecerli_i = 1'b1;
        bus.bellek_veri_i         = words[0];
        tick();
        bus.bellek_veri_gecerli_i = 1'b0;
        request_word(32'h0000_2000, 1, 1'b0);
        n = 0;
        while (!bus.hazir_o && n < 4 * L) begin
            tick();
            n++;
        end
        chk("zamanasimi_hazir", bus.hazir_o, 1);
        chk("zamanasimi_hata", bus.hata_o, 1);
        chk("zamanasimi_sure", 128'(n), 128'(L));
        chk("zamanasimi_obek_ust", bus.obek_o[127:32], 96'd0);
        chk("zamanasimi_obek_alt", bus.obek_o[31:0], words[0]);
        exp_blk = bus.obek_o;
        tick();
        chk("zamanasimi_sonra_musait", bus.musait_o, 1);
        chk("zamanasimi_sonra_hazir", bus.hazir_o, 0);
        chk("zamanasimi_sonra_hata", bus.hata_o, 0);
        chk("zamanasimi_obek_tutuldu", bus.obek_o, {96'd0, words[0]});

        // Reset while waiting for word 2, then late data after release.
        words = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
        accept(32'h0000_3000, t0);
        for (int w = 0; w < 2; w++) begin
            request_word(32'h0000_3000, w, 1'b0);
            bus.bellek_veri_gecerli_i = 1'b1;
            bus.bellek_veri_i         = words[w];
            tick();
            bus.bellek_veri_gecerli_i = 1'b0;
        end
        request_word(32'h0000_3000, 2, 1'b0);
        rst_i = 1'b0;
        #1;
        check_reset_outputs("reset_ortada");
        tick();
        rst_i = 1'b1;
        bus.bellek_veri_gecerli_i = 1'b1;
        bus.bellek_veri_i         = words[2];
        for (int c = 0; c < 4; c++) begin
            tick();
            check_reset_outputs("reset_sonrasi_veri");
        end
        clear_inputs();

        // Normal operation resumes after the abandoned block.
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom;
            hs[i]    = 1;
            dl[i]    = 2;
        end
        run_block(32'h7654_3210, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/anabellek_obek_okuyucu.md
ANABELLEK_OBEK_OKUYUCU -- requirements
Module: anabellek_obek_okuyucu

Interface
REQ-001 Parameter: BEKLEME_SINIRI, default 1023, maximum cycles spent in BEKLE for one word before abort.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk_i  in  1  clock, all state updates on rising edge.
REQ-004 rst_i  in  1  asynchronous active-low reset.
REQ-005 istek_i  in  1  block read request from the instruction cache.
REQ-006 oku_i  in  1  read qualifier; must be 1 for a request to be accepted.
REQ-007 adres_i  in  32  request address; bits [3:0] ignored.
REQ-008 musait_o  out  1  controller idle, a request may be accepted this cycle.
REQ-009 hazir_o  out  1  one-cycle pulse, obek_o complete.
REQ-010 obek_o  out  128  assembled 16-byte block.
REQ-011 hata_o  out  1  one-cycle pulse coincident with hazir_o when the block was aborted by timeout.
REQ-012 bellek_gecerli_o  out  1  word read request valid on the memory bus.
REQ-013 bellek_adres_o  out  32  word address on the memory bus.
REQ-014 bellek_hazir_i  in  1  memory accepts the request in the cycle it and bellek_gecerli_o are both 1.
REQ-015 bellek_veri_gecerli_i  in  1  read data valid.
REQ-016 bellek_veri_i  in  32  read data word.

Function
REQ-017 States: BOSTA, ISTEK, BEKLE, TAMAM. Only one word read outstanding at a time.
REQ-018 musait_o SHALL be 1 exactly when state is BOSTA.
REQ-019 Acceptance: in BOSTA with istek_i=1 and oku_i=1. Latch base = {adres_i[31:4],4'b0000}. Clear word counter k to 0 and obek_o to 0. Go to ISTEK.
REQ-020 istek_i with oku_i=0, or istek_i in any state other than BOSTA, SHALL be ignored with no side effects.
REQ-021 ISTEK: bellek_gecerli_o=1 and bellek_adres_o=base+4*k, both held stable until bellek_hazir_i=1. Go to BEKLE on the handshake cycle.
REQ-022 bellek_gecerli_o SHALL be 0 and bellek_adres_o SHALL be 0 in all states other than ISTEK.
REQ-023 BEKLE: on bellek_veri_gecerli_i=1, capture bellek_veri_i into obek_o[32k+31:32k] (little-endian word order). Increment k. Go to TAMAM if k was 3, else to ISTEK.
REQ-024 bellek_veri_gecerli_i SHALL be ignored outside BEKLE.
REQ-025 Timeout counter: cleared on every entry to BEKLE, incremented each BEKLE cycle without data. On reaching BEKLEME_SINIRI, go to TAMAM with the error flag set; uncaptured words remain 0.
REQ-026 TAMAM (one cycle): hazir_o=1, hata_o=error flag. Next state is BOSTA; the error flag is cleared on leaving TAMAM.
REQ-027 obek_o SHALL hold its value from TAMAM until the next acceptance.
REQ-028 Zero-wait memory (bellek_hazir_i=1 always, data the cycle after handshake): acceptance at cycle N gives hazir_o at cycle N+9.
REQ-029 istek_i asserted during TAMAM is not accepted; the earliest next acceptance is the BOSTA cycle that follows.
REQ-030 k is 2 bits wide; address arithmetic is 32-bit with no carry into base[31:4] (offsets 0,4,8,12 only).

Reset
REQ-031 rst_i=0 SHALL immediately force state BOSTA, k=0, timeout counter=0, error flag=0, obek_o=0.
REQ-032 Output values under reset: musait_o=1; hazir_o=0; hata_o=0; bellek_gecerli_o=0; bellek_adres_o=0.
REQ-033 Reset mid-operation SHALL abandon the block. No hazir_o pulse SHALL follow. Data returning after reset release while in BOSTA SHALL be ignored.

Verification
REQ-034 Zero-wait read: istek_i=1, oku_i=1, adres_i=0x0000_1238; memory returns 0x11,0x22,0x33,0x44 for 0x1230..0x123C -> bus addresses 0x1230,0x1234,0x1238,0x123C in order; hazir_o at N+9; obek_o=0x00000044_00000033_00000022_00000011; hata_o=0.
REQ-035 Backpressure: bellek_hazir_i held 0 for 5 cycles on word 2 -> bellek_adres_o=base+8 stable and bellek_gecerli_o=1 throughout; hazir_o delayed by exactly 5 cycles.
REQ-036 Busy/invalid request: istek_i pulsed while in BEKLE, and istek_i with oku_i=0 while in BOSTA -> neither accepted; musait_o stays as defined by state; bus sequence unchanged.
REQ-037 Timeout with BEKLEME_SINIRI=8: no data on word 1 -> hazir_o=1 and hata_o=1 on the same cycle; obek_o[127:32]=0; musait_o=1 on the following cycle.
REQ-038 Reset mid-block: rst_i low during BEKLE of word 2, then bellek_veri_gecerli_i=1 after release -> outputs at reset values; no hazir_o pulse; obek_o=0.
